// File: rtl/ring_osc_freq_meter.sv
// Ring-oscillator frequency meter.
// Counts rising edges of the (divided) oscillator pin over a programmable
// window of gate_len+1 system clocks and reports a held, saturating result.
//
// Ports:
//   clk       system clock, all logic on posedge
//   rst_n     synchronous active-low reset
//   osc_in    oscillator signal, asynchronous to clk
//   start     measurement request, accepted in IDLE/DONE
//   gate_len  window length minus one, latched on accepted start
//   busy      high while arming or gating
//   valid     one-cycle strobe when result/overflow update
//   result    edge count of the last completed measurement
//   overflow  last completed measurement saturated
module ring_osc_freq_meter #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned GATE_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              osc_in,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  output logic              busy,
  output logic              valid,
  output logic [CNT_W-1:0]  result,
  output logic              overflow
);

  localparam int unsigned CNT_W1 = CNT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_GATE = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e            state_q;
  logic              s1_q, s2_q, s3_q;
  logic              arm_q;
  logic [GATE_W-1:0] glen_q;
  logic [GATE_W-1:0] gcnt_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_acc_q;

  logic              rise_c;
  logic [CNT_W:0]    inc_c;
  logic [CNT_W-1:0]  cnt_d;
  logic              ovf_d;

  // Rising edge seen on the synchronized oscillator.
  assign rise_c = s2_q & ~s3_q;

  // Saturating increment: carry out of the widened sum clamps to all-ones.
  assign inc_c = CNT_W1'(cnt_q) + CNT_W1'(1);

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_acc_q;
    if (rise_c) begin
      if (inc_c[CNT_W]) begin
        cnt_d = '1;
        ovf_d = 1'b1;
      end else begin
        cnt_d = inc_c[CNT_W-1:0];
      end
    end
  end

  // Synchronizer, measurement FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      arm_q     <= 1'b0;
      glen_q    <= '0;
      gcnt_q    <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
    end else begin
      s1_q  <= osc_in;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      valid <= 1'b0;

      case (state_q)
        // DONE only differs from IDLE in that result holds a measurement.
        S_IDLE, S_DONE: begin
          if (start) begin
            glen_q    <= gate_len;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            arm_q     <= 1'b0;
            busy      <= 1'b1;
            state_q   <= S_ARM;
          end else begin
            state_q <= S_IDLE;
          end
        end

        // Two cycles with rise ignored, flushing stale synchronizer history.
        S_ARM: begin
          if (arm_q) begin
            gcnt_q  <= '0;
            state_q <= S_GATE;
          end else begin
            arm_q <= 1'b1;
          end
        end

        // The cycle with gcnt == glen is still counted, then results publish.
        S_GATE: begin
          cnt_q     <= cnt_d;
          ovf_acc_q <= ovf_d;
          if (gcnt_q == glen_q) begin
            result   <= cnt_d;
            overflow <= ovf_d;
            valid    <= 1'b1;
            busy     <= 1'b0;
            state_q  <= S_DONE;
          end else begin
            gcnt_q <= gcnt_q + GATE_W'(1);
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
// Self-checking bench for ring_osc_freq_meter: table of periodic-input
// measurements with known counts, hand sequences for reset/abort/busy/
// back-to-back, and random oscillator waveforms checked against a model that
// counts 0->1 transitions of the clock-sampled pin over the gate window.
module tb_ring_osc_freq_meter;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned GATE_W = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              osc_in;
  logic              start;
  logic [GATE_W-1:0] gate_len;
  logic              busy;
  logic              valid;
  logic [CNT_W-1:0]  result;
  logic              overflow;

  always #5 clk = ~clk;

  ring_osc_freq_meter #(.CNT_W(CNT_W), .GATE_W(GATE_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .osc_in   (osc_in),
    .start    (start),
    .gate_len (gate_len),
    .busy     (busy),
    .valid    (valid),
    .result   (result),
    .overflow (overflow)
  );

  typedef struct {
    int    g;
    int    per;
    int    hi;
    int    exp_res;
    bit    exp_ovf;
    bit    pulse;
    string name;
  } vec_t;

  vec_t tbl[9];

  int nvec = 0;
  int nerr = 0;

  // Pin level as seen by the synchronizer at each posedge (0 while in reset).
  bit hist[$];

  int osc_mode;  // 0 static, 1 periodic, 2 random
  int osc_per, osc_hi, osc_ph, osc_rem;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic gen_osc();
    case (osc_mode)
      1: begin
        osc_ph = (osc_ph + 1) % osc_per;
        osc_in = (osc_ph < osc_hi);
      end
      2: begin
        osc_rem--;
        if (osc_rem <= 0) begin
          osc_in  = ~osc_in;
          osc_rem = int'($urandom_range(1, 6));
        end
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    hist.push_back(rst_n ? osc_in : 1'b0);
    #1;
    gen_osc();
  endtask

  // Reference: rising transitions of the sampled pin in sample range [lo, hi].
  function automatic void model(input int lo, input int hi, output int res, output bit ovf);
    int c = 0;
    for (int j = lo; j <= hi; j++)
      if (hist[j] && !hist[j-1]) c++;
    ovf = (c > 255);
    res = ovf ? 255 : c;
  endfunction

  task automatic set_periodic(input int per, input int hi);
    osc_mode = 1;
    osc_per  = per;
    osc_hi   = hi;
    osc_ph   = 0;
    osc_in   = 1'b1;
  endtask

  // One full measurement from idle: latency, busy and strobe checks.
  task automatic measure(input int g, input string nm, input bit pulse,
                         output int t, output int r, output bit o);
    int n;
    gate_len = GATE_W'(g);
    start    = 1'b1;
    tick();
    t        = hist.size() - 1;
    start    = 1'b0;
    gate_len = GATE_W'($urandom);
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!valid && n < g + 20) begin
      start = pulse && (n == 8 || n == 28);
      tick();
      n++;
    end
    start = 1'b0;
    chk({nm, "_latency"}, 32'(n), 32'(g + 3));
    chk({nm, "_busy_at_valid"}, 32'(busy), 32'd0);
    r = int'(result);
    o = overflow;
    tick();
    chk({nm, "_valid_one_cycle"}, 32'(valid), 32'd0);
  endtask

  initial begin
    int t, t1, t2, r, r1, er, n, nv, unstable;
    bit o, eo;

    tbl[0] = '{99,   10, 5, 10,  1'b0, 1'b0, "exact"};
    tbl[1] = '{4095, 4,  2, 255, 1'b1, 1'b0, "sat"};
    tbl[2] = '{39,   4,  2, 10,  1'b0, 1'b0, "post_sat"};
    tbl[3] = '{3,    4,  2, 1,   1'b0, 1'b0, "short_window"};
    tbl[4] = '{1019, 4,  2, 255, 1'b0, 1'b0, "exact_255"};
    tbl[5] = '{1023, 4,  2, 255, 1'b1, 1'b0, "first_over"};
    tbl[6] = '{59,   6,  3, 10,  1'b0, 1'b0, "period6"};
    tbl[7] = '{255,  8,  2, 32,  1'b0, 1'b0, "period8"};
    tbl[8] = '{49,   10, 5, 5,   1'b0, 1'b1, "start_while_busy"};

    // Reset held with start high and a toggling pin.
    rst_n    = 1'b0;
    start    = 1'b1;
    gate_len = GATE_W'(5);
    osc_in   = 1'b0;
    osc_mode = 1;
    osc_per  = 2;
    osc_hi   = 1;
    osc_ph   = 0;
    osc_rem  = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
    end
    rst_n = 1'b1;
    start = 1'b0;
    tick();
    chk("rel_busy", 32'(busy), 32'd0);
    chk("rel_valid", 32'(valid), 32'd0);
    chk("rel_result", 32'(result), 32'd0);
    chk("rel_overflow", 32'(overflow), 32'd0);

    // Periodic inputs with counts known from the window length.
    foreach (tbl[i]) begin
      set_periodic(tbl[i].per, tbl[i].hi);
      repeat (6) tick();
      measure(tbl[i].g, tbl[i].name, tbl[i].pulse, t, r, o);
      chk({tbl[i].name, "_result"}, 32'(r), 32'(tbl[i].exp_res));
      chk({tbl[i].name, "_overflow"}, 32'(o), 32'(tbl[i].exp_ovf));
    end

    // Pin stuck high before start: the old level is not an edge.
    osc_mode = 0;
    osc_in   = 1'b1;
    repeat (5) tick();
    measure(20, "static_high", 1'b0, t, r, o);
    chk("static_high_result", 32'(r), 32'd0);
    chk("static_high_overflow", 32'(o), 32'd0);

    // Reset during GATE aborts the measurement and clears result.
    set_periodic(10, 5);
    repeat (3) tick();
    gate_len = GATE_W'(50);
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_overflow", 32'(overflow), 32'd0);
    nv = 0;
    repeat (70) begin
      tick();
      if (valid) nv++;
    end
    chk("abort_no_valid", 32'(nv), 32'd0);
    chk("abort_busy_after", 32'(busy), 32'd0);
    measure(29, "after_abort", 1'b0, t, r, o);
    chk("after_abort_result", 32'(r), 32'd3);

    // Random waveforms and window lengths against the model.
    osc_mode = 2;
    osc_rem  = 1;
    for (int i = 0; i < 25; i++) begin
      int g;
      g = int'($urandom_range(0, 300));
      if ($urandom_range(0, 3) == 0) g = int'($urandom_range(0, 3));
      repeat (int'($urandom_range(0, 7))) tick();
      measure(g, "rand", 1'b0, t, r, o);
      model(t + 1, t + 1 + g, er, eo);
      chk("rand_result", 32'(r), 32'(er));
      chk("rand_overflow", 32'(o), 32'(eo));
    end

    // Start held high: second measurement accepted in the valid cycle.
    gate_len = GATE_W'(19);
    start    = 1'b1;
    tick();
    t1 = hist.size() - 1;
    n  = 0;
    while (!valid && n < 40) begin
      tick();
      n++;
    end
    chk("b2b_first_latency", 32'(n), 32'd22);
    model(t1 + 1, t1 + 20, er, eo);
    chk("b2b_first_result", 32'(result), 32'(er));
    chk("b2b_first_overflow", 32'(overflow), 32'(eo));
    r1 = int'(result);
    tick();
    t2 = hist.size() - 1;
    chk("b2b_gap_valid", 32'(valid), 32'd0);
    chk("b2b_gap_busy", 32'(busy), 32'd1);
    n        = 0;
    unstable = 0;
    while (!valid && n < 40) begin
      if (result !== CNT_W'(r1)) unstable++;
      tick();
      n++;
    end
    start = 1'b0;
    chk("b2b_second_latency", 32'(n), 32'd22);
    chk("b2b_result_held", 32'(unstable), 32'd0);
    model(t2 + 1, t2 + 20, er, eo);
    chk("b2b_second_result", 32'(result), 32'(er));
    chk("b2b_second_overflow", 32'(overflow), 32'(eo));
    tick();
    chk("b2b_end_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
